// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: stage occupancy states, default stage widths
// and the bubble control value used by every inter-stage register.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  localparam int PIPE_DATA_W = 128;
  localparam int PIPE_CTRL_W = 12;
  localparam logic [PIPE_CTRL_W-1:0] PIPE_CTRL_BUBBLE = '0;

  // Saturating 8-bit accumulate used for discarded-beat statistics.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between a pipeline stage register and its
// upstream producer / downstream consumer.
interface pipe_stage_reg_if
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  // master: the environment around the stage (producer + consumer)
  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  // slave: the stage register itself
  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Two-entry elastic pipeline register (main + skid) with flush, bubble
// insertion on the control bundle and a saturating dropped-beat counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W      = PIPE_DATA_W,
  parameter int                CTRL_W      = PIPE_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(PIPE_CTRL_BUBBLE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  pipe_stage_reg_if.slave   bus,
  output logic [1:0]        occupancy,
  output logic [7:0]        drop_cnt
);

  stage_state_e      state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [7:0]        drop_q, drop_d;
  logic              ready_en_q;
  logic              push, pop;

  // in_ready comes purely from registers; ready_en_q keeps it low during reset.
  assign bus.in_ready  = ready_en_q && (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_ctrl  = bus.out_valid ? main_ctrl_q : CTRL_BUBBLE;
  assign bus.out_data  = main_data_q;
  assign occupancy     = 2'(state_q);
  assign drop_cnt      = drop_q;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    drop_d      = drop_q;
    if (flush) begin
      state_d = EMPTY;
      drop_d  = sat_add8(drop_q, occupancy + {1'b0, push});
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d     = HALF;
            main_ctrl_d = bus.in_ctrl;
            main_data_d = bus.in_data;
          end
        end
        HALF: begin
          case ({push, pop})
            2'b10: begin
              state_d     = FULL;
              skid_ctrl_d = bus.in_ctrl;
              skid_data_d = bus.in_data;
            end
            2'b01: state_d = EMPTY;
            2'b11: begin
              main_ctrl_d = bus.in_ctrl;
              main_data_d = bus.in_data;
            end
            default: state_d = HALF;
          endcase
        end
        FULL: begin
          // Skid entry is older than anything still upstream, so it advances.
          if (pop) begin
            state_d     = HALF;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      drop_q      <= '0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      drop_q      <= drop_d;
      ready_en_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus randomized traffic checked
// against a queue-based reference of the elastic stage.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int DW = 32;
  localparam int CW = 12;
  localparam logic [CW-1:0] BUB = 12'h5A5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] occupancy;
  logic [7:0] drop_cnt;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit verbose = 1'b1;

  // Reference: a FIFO of at most two beats plus the last head shown on out_data.
  logic [CW-1:0] q_ctrl[$];
  logic [DW-1:0] q_data[$];
  bit            m_ready_en;
  int            m_drop;
  logic [DW-1:0] m_last;

  task automatic drive(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input bit ordy, input bit fl);
    bus.in_valid  = v;
    bus.in_ctrl   = c;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  task automatic cycle();
    int sz;
    bit push, pop;
    sz   = q_data.size();
    push = bus.in_valid && m_ready_en && (sz < 2);
    pop  = (sz > 0) && bus.out_ready;
    @(posedge clk);
    if (flush) begin
      m_drop = (m_drop + sz + int'(push) > 255) ? 255 : m_drop + sz + int'(push);
      q_ctrl.delete();
      q_data.delete();
    end else begin
      if (pop) begin
        if (verbose) $display("[%0t] beat out ctrl=%h data=%h", $time, q_ctrl[0], q_data[0]);
        void'(q_ctrl.pop_front());
        void'(q_data.pop_front());
      end
      if (push) begin
        q_ctrl.push_back(bus.in_ctrl);
        q_data.push_back(bus.in_data);
      end
    end
    if (q_data.size() > 0) m_last = q_data[0];
    m_ready_en = 1'b1;
    #1;
  endtask

  task automatic apply_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    q_ctrl.delete();
    q_data.delete();
    m_ready_en = 1'b0;
    m_drop     = 0;
    m_last     = '0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #2;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 0 0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.out_ctrl !== BUB || bus.out_data !== '0) begin
      errors++;
      $display("FAIL reset_bus: ctrl=%h data=%h, required %h 0", bus.out_ctrl, bus.out_data, BUB);
    end
    checks++;
    if (occupancy !== 2'd0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_counts: occ=%0d drop=%0d, required 0 0", occupancy, drop_cnt);
    end
    release_reset();
    cycle();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, CW'(i + 1), vals[i], 1'b1, 1'b0);
      cycle();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== vals[i] || bus.out_ctrl !== CW'(i + 1)) begin
        errors++;
        $display("FAIL stream_out%0d: v=%b ctrl=%h data=%h, required 1 %h %h",
                 i, bus.out_valid, bus.out_ctrl, bus.out_data, CW'(i + 1), vals[i]);
      end
      checks++;
      if (occupancy !== 2'd1) begin
        errors++;
        $display("FAIL stream_occ%0d: occ=%0d, required 1", i, occupancy);
      end
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cycle();
    checks++;
    if (occupancy !== 2'd0 || bus.out_ctrl !== BUB || bus.out_data !== 32'h33) begin
      errors++;
      $display("FAIL stream_drain: occ=%0d ctrl=%h data=%h, required 0 %h 33", occupancy, bus.out_ctrl, bus.out_data, BUB);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 12'h00A, 32'hA, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 12'h00B, 32'hB, 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (occupancy !== 2'd2 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_full: occ=%0d in_ready=%b, required 2 0", occupancy, bus.in_ready);
    end
    cycle();
    checks++;
    if (occupancy !== 2'd2 || bus.out_data !== 32'hA) begin
      errors++;
      $display("FAIL stall_hold: occ=%0d data=%h, required 2 a", occupancy, bus.out_data);
    end
    bus.out_ready = 1'b1;
    cycle();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_data !== 32'hB || bus.out_ctrl !== 12'h00B || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL stall_pop1: rdy=%b data=%h ctrl=%h occ=%0d, required 1 b 00b 1",
               bus.in_ready, bus.out_data, bus.out_ctrl, occupancy);
    end
    cycle();
    checks++;
    if (occupancy !== 2'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_pop2: occ=%0d v=%b, required 0 0", occupancy, bus.out_valid);
    end
  endtask

  task automatic test_flush_full();
    drive(1'b1, 12'h00C, 32'hC, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 12'h00D, 32'hD, 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    cycle();
    flush = 1'b0;
    checks++;
    if (occupancy !== 2'd0 || bus.out_valid !== 1'b0 || bus.out_ctrl !== BUB) begin
      errors++;
      $display("FAIL flush_full_state: occ=%0d v=%b ctrl=%h, required 0 0 %h", occupancy, bus.out_valid, bus.out_ctrl, BUB);
    end
    checks++;
    if (drop_cnt !== 8'd2) begin
      errors++;
      $display("FAIL flush_full_drop: drop=%0d, required 2", drop_cnt);
    end
  endtask

  task automatic test_flush_half();
    drive(1'b1, 12'h00E, 32'hE, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 12'h00F, 32'hF, 1'b0, 1'b1);
    cycle();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (drop_cnt !== 8'd4 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL flush_half_drop: drop=%0d occ=%0d, required 4 0", drop_cnt, occupancy);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_half_stray%0d: out_valid=%b, required 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_saturation();
    verbose = 1'b0;
    for (int i = 0; i < 130; i++) begin
      drive(1'b1, CW'(i), DW'(i), 1'b0, 1'b0);
      cycle();
      drive(1'b1, CW'(i), DW'(i + 1000), 1'b0, 1'b1);
      cycle();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL saturation: drop=%0d, required 255", drop_cnt);
    end
    verbose = 1'b1;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 12'h123, 32'hCAFE, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 12'h456, 32'hBEEF, 1'b0, 1'b0);
    cycle();
    #2;
    apply_reset();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || occupancy !== 2'd0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_state: v=%b rdy=%b occ=%0d drop=%0d, required 0 0 0 0",
               bus.out_valid, bus.in_ready, occupancy, drop_cnt);
    end
    checks++;
    if (bus.out_ctrl !== BUB || bus.out_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_bus: ctrl=%h data=%h, required %h 0", bus.out_ctrl, bus.out_data, BUB);
    end
    release_reset();
    cycle();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: rdy=%b v=%b, required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_random();
    logic [CW+DW+12:0] obs, exp;
    int sz;
    verbose = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 9) < 7, CW'($urandom), DW'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0);
      cycle();
      sz  = q_data.size();
      obs = {bus.in_ready, bus.out_valid, occupancy, drop_cnt, bus.out_ctrl, bus.out_data};
      exp = {m_ready_en && (sz < 2), sz > 0, 2'(sz), 8'(m_drop),
             (sz > 0) ? q_ctrl[0] : BUB, m_last};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random_cycle%0d: {rdy,v,occ,drop,ctrl,data}=%h, required %h", i, obs, exp);
      end
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    verbose = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_full();
    test_flush_half();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning the width of the payload datapath (operands, ALU result, next-PC).
REQ-002 SHALL have parameter CTRL_W, default 12, meaning the width of the control bundle (MemRead, MemWrite, RegWrite, BHW, RegDst, MemToReg, ...).
REQ-003 SHALL have parameter CTRL_BUBBLE, default all-zero CTRL_W vector, meaning the control value presented for a bubble (no memory or register side effects).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port flush, input, 1 bit: synchronous squash of all held and incoming beats.
REQ-007 SHALL have port in_valid, input, 1 bit: upstream beat present.
REQ-008 SHALL have port in_ready, output, 1 bit: stage can accept a beat.
REQ-009 SHALL have port in_ctrl, input, CTRL_W bits: upstream control bundle.
REQ-010 SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-011 SHALL have port out_valid, output, 1 bit: downstream beat present.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts (low = stall).
REQ-013 SHALL have port out_ctrl, output, CTRL_W bits: held control, or CTRL_BUBBLE when out_valid=0.
REQ-014 SHALL have port out_data, output, DATA_W bits: held payload.
REQ-015 SHALL have port occupancy, output, 2 bits: number of held beats (0..2).
REQ-016 SHALL have port drop_cnt, output, 8 bits: saturating count of valid beats discarded by flush.

Function
REQ-017 SHALL implement a 2-entry elastic stage (main + skid register); states EMPTY (occ 0), HALF (occ 1), FULL (occ 2).
REQ-018 SHALL drive in_ready = (state != FULL), from registered state only (no combinational out_ready->in_ready path).
REQ-019 SHALL accept a beat when in_valid & in_ready and pop one when out_valid & out_ready; out_valid = (state != EMPTY).
REQ-020 SHALL give a latency of 1 cycle from acceptance into EMPTY to out_valid; sustained throughput 1 beat/cycle when out_ready=1.
REQ-021 SHALL use transitions: EMPTY->HALF on push; HALF->FULL on push without pop; HALF->EMPTY on pop without push; HALF stays on push+pop; FULL->HALF on pop; push is impossible in FULL.
REQ-022 SHALL preserve strict FIFO order; on FULL->HALF the skid entry moves to main in the same edge.
REQ-023 SHALL, when out_valid=0, force out_ctrl=CTRL_BUBBLE; out_data holds its last value (no datapath clear).
REQ-024 SHALL give flush priority over push and pop: next state EMPTY, incoming beat discarded, downstream pop that cycle is still considered taken by downstream but ignored internally.
REQ-025 SHALL add occupancy plus (in_valid & in_ready) to drop_cnt on flush, saturating at 255.
REQ-026 SHALL keep state, occupancy and outputs unchanged while in_valid=0, out_ready=0, flush=0.

Reset
REQ-027 SHALL, while rst=0, asynchronously force state EMPTY, out_valid=0, in_ready=0, out_ctrl=CTRL_BUBBLE, out_data=0, occupancy=0, drop_cnt=0.
REQ-028 SHALL assert in_ready=1 on the first rising clk after rst deasserts; beats in flight at reset assertion are lost and not counted.

Structure
REQ-029 SHALL take the state encoding (EMPTY/HALF/FULL) and the default CTRL_W/CTRL_BUBBLE from the shared pipeline package also used by the IF/ID, ID/EX and MEM/WB stages.
REQ-030 SHALL be a single module; no sub-module is required, and one instance replaces each fixed-field stage register.

Verification
REQ-031 SHALL cover streaming: push 0x11,0x22,0x33 on consecutive cycles, out_ready=1 -> same values out 1 cycle later, occupancy never exceeds 1.
REQ-032 SHALL cover stall: push 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0 next cycle; raise out_ready -> 0xA then 0xB, in_ready=1 after first pop.
REQ-033 SHALL cover flush when FULL with in_valid=0 -> next cycle occupancy=0, out_valid=0, out_ctrl=CTRL_BUBBLE, drop_cnt=2.
REQ-034 SHALL cover flush with in_valid=1 from HALF -> beat discarded, drop_cnt +2, no stray beat emerges.
REQ-035 SHALL cover saturation: 130 flushes each dropping 2 beats -> drop_cnt=255.
REQ-036 SHALL cover reset mid-operation: rst low while FULL -> outputs zero/bubble immediately without clk, in_ready=1 one edge after release.
